// File: rtl/mem_if_arbiter.sv
// Round-robin arbiter that shares one synchronous single-port RAM between NUM_CH
// start/finish requesters; RAM read latency is set by RD_LAT.
module mem_if_arbiter #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         start,
  input  logic [NUM_CH-1:0]         readWrite,
  input  logic [NUM_CH*ADDR_W-1:0]  fsm_adr,
  input  logic [NUM_CH*DATA_W-1:0]  fsm_wdata,
  output logic [NUM_CH-1:0]         finish,
  output logic [NUM_CH*DATA_W-1:0]  fsm_rdata,
  output logic [ADDR_W-1:0]         mem_adr,
  output logic                      mem_we,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy,
  output logic [$clog2(NUM_CH)-1:0] grant_ch
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);
  localparam logic [CH_W-1:0]  LAST_RST = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_DONE} state_t;

  state_t                        state_q, state_d;
  logic [CH_W-1:0]               last_q, last_d, sel, grant_d;
  logic                          sel_vld, rw_q, rw_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [NUM_CH-1:0][ADDR_W-1:0] adr_arr;
  logic [NUM_CH-1:0][DATA_W-1:0] wdata_arr, rdata_q, rdata_d;
  logic [NUM_CH-1:0]             finish_d;
  logic [ADDR_W-1:0]             adr_d;
  logic [DATA_W-1:0]             wdata_d;
  logic                          we_d, busy_d;

  assign adr_arr   = fsm_adr;
  assign wdata_arr = fsm_wdata;
  assign fsm_rdata = rdata_q;

  function automatic logic [CH_W-1:0] rr_next(input logic [CH_W-1:0] base, input int k);
    return CH_W'((int'(base) + k) % int'(NUM_CH));
  endfunction

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      last_q    <= LAST_RST;
      rw_q      <= 1'b0;
      cnt_q     <= '0;
      finish    <= '0;
      rdata_q   <= '0;
      mem_adr   <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      grant_ch  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      rw_q      <= rw_d;
      cnt_q     <= cnt_d;
      finish    <= finish_d;
      rdata_q   <= rdata_d;
      mem_adr   <= adr_d;
      mem_we    <= we_d;
      mem_wdata <= wdata_d;
      busy      <= busy_d;
      grant_ch  <= grant_d;
    end
  end

  // Next state; the lowest k wins, i.e. the first requester after last
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    state_d = state_q;
    for (int k = int'(NUM_CH); k > 0; k--) begin
      if (start[rr_next(last_q, k)]) begin
        sel     = rr_next(last_q, k);
        sel_vld = 1'b1;
      end
    end
    case (state_q)
      ST_IDLE:   if (sel_vld) state_d = ST_ACCESS;
      ST_ACCESS: state_d = rw_q ? ST_DONE : ST_WAIT;
      ST_WAIT:   if (cnt_q == CNT_LAST) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and latched request
  always_comb begin
    last_d   = last_q;
    rw_d     = rw_q;
    cnt_d    = cnt_q;
    grant_d  = grant_ch;
    adr_d    = mem_adr;
    wdata_d  = mem_wdata;
    rdata_d  = rdata_q;
    we_d     = 1'b0;
    finish_d = '0;
    busy_d   = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (sel_vld) begin
          last_d  = sel;
          grant_d = sel;
          rw_d    = readWrite[sel];
          adr_d   = adr_arr[sel];
          wdata_d = wdata_arr[sel];
          we_d    = readWrite[sel];
          cnt_d   = '0;
        end
      end
      ST_ACCESS: cnt_d = '0;
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) rdata_d[grant_ch] = mem_rdata;
      end
      default: ;
    endcase
    if (state_d == ST_DONE) finish_d[grant_d] = 1'b1;
  end

endmodule

// File: tb/tb_mem_if_arbiter.sv
// Bench for mem_if_arbiter: directed vector table, corner-case sequences and a
// randomized phase checked against a transaction-level round-robin model.
module tb_mem_if_arbiter;
  localparam int NCH = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NCH-1:0]   start, rw, finish;
  logic [NCH*8-1:0] adr, wdata, rdata;
  logic [7:0]       mem_adr, mem_wdata, mem_rdata;
  logic             mem_we, busy;
  logic [1:0]       grant;

  logic [NCH-1:0]   start3, rw3, finish3;
  logic [NCH*8-1:0] adr3, wdata3, rdata3;
  logic [7:0]       mem_adr3, mem_wdata3, mem_rdata3;
  logic             mem_we3, busy3;
  logic [1:0]       grant3;
  logic [7:0]       cyc3 = 8'h00;

  logic [7:0] ram     [256];
  logic [7:0] ref_mem [256];
  logic [7:0] exp_rd  [NCH];
  int n_chk = 0;
  int n_err = 0;

  always @(posedge clk) begin
    if (mem_we) ram[mem_adr] <= mem_wdata;
    mem_rdata <= ram[mem_adr];
  end
  always @(posedge clk) cyc3 <= cyc3 + 8'd1;
  assign mem_rdata3 = cyc3;

  mem_if_arbiter #(.NUM_CH(3), .ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .start(start), .readWrite(rw), .fsm_adr(adr),
    .fsm_wdata(wdata), .finish(finish), .fsm_rdata(rdata), .mem_adr(mem_adr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
    .grant_ch(grant));

  mem_if_arbiter #(.NUM_CH(3), .ADDR_W(8), .DATA_W(8), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .readWrite(rw3), .fsm_adr(adr3),
    .fsm_wdata(wdata3), .finish(finish3), .fsm_rdata(rdata3), .mem_adr(mem_adr3),
    .mem_we(mem_we3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3),
    .grant_ch(grant3));

  typedef struct {
    int         ch;
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    int         lat;
    logic [7:0] rd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NCH*8-1:0] exp_vec();
    logic [NCH*8-1:0] v;
    for (int i = 0; i < NCH; i++) v[i*8 +: 8] = exp_rd[i];
    return v;
  endfunction

  task automatic set_ch(input int ch, input logic st, input logic w,
                        input logic [7:0] a, input logic [7:0] d);
    start[ch]        = st;
    rw[ch]           = w;
    adr[ch*8 +: 8]   = a;
    wdata[ch*8 +: 8] = d;
  endtask

  task automatic clear_inputs();
    start = '0; rw = '0; adr = '0; wdata = '0;
    start3 = '0; rw3 = '0; adr3 = '0; wdata3 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    for (int i = 0; i < NCH; i++) exp_rd[i] = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_finish"}, 32'(finish), 32'd0);
    chk({tag, "_rdata"}, 32'(rdata), 32'd0);
    chk({tag, "_mem_adr"}, 32'(mem_adr), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
  endtask

  // Negedges until finish[ch]; -1 if the bound expires
  task automatic wait_fin(input int ch, input int maxc, output int lat);
    lat = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (finish[ch]) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    vec_t vt [6];
    int lat, found, f0, f2, g2, cand, mlast, next_arb, arb_c, done_c, g_ch;
    logic [7:0] base, g_a, g_d;
    logic g_w;
    logic [NCH-1:0] exp_fin;
    logic [7:0] rr_val [NCH];

    clear_inputs();
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    ram[8'h15] = 8'hBB;
    for (int i = 0; i < NCH; i++) exp_rd[i] = 8'h00;

    vt[0] = '{0, 1'b0, 8'h15, 8'h00, 3, 8'hBB};
    vt[1] = '{1, 1'b1, 8'h20, 8'h5A, 2, 8'h00};
    vt[2] = '{2, 1'b0, 8'h20, 8'h00, 3, 8'h5A};
    vt[3] = '{1, 1'b0, 8'h15, 8'h00, 3, 8'hBB};
    vt[4] = '{0, 1'b1, 8'hFF, 8'hC3, 2, 8'h00};
    vt[5] = '{2, 0, 8'hFF, 8'h00, 3, 8'hC3};

    #2 reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst");
    chk("rst3_busy", 32'(busy3), 32'd0);
    chk("rst3_rdata", 32'(rdata3), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Directed vector table, one transaction at a time from IDLE
    for (int i = 0; i < 6; i++) begin
      set_ch(vt[i].ch, 1'b1, vt[i].w, vt[i].a, vt[i].d);
      @(negedge clk);
      chk("vec_adr", 32'(mem_adr), 32'(vt[i].a));
      chk("vec_we", 32'(mem_we), 32'(vt[i].w));
      chk("vec_busy", 32'(busy), 32'd1);
      if (vt[i].w) chk("vec_wdata", 32'(mem_wdata), 32'(vt[i].d));
      wait_fin(vt[i].ch, 8, lat);
      chk("vec_lat", 32'(lat + 1), 32'(vt[i].lat));
      chk("vec_fin", 32'(finish), 32'(1) << vt[i].ch);
      chk("vec_grant", 32'(grant), 32'(vt[i].ch));
      if (!vt[i].w) exp_rd[vt[i].ch] = vt[i].rd;
      chk("vec_rdata", 32'(rdata), 32'(exp_vec()));
      set_ch(vt[i].ch, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      chk("vec_idle_busy", 32'(busy), 32'd0);
      chk("vec_idle_fin", 32'(finish), 32'd0);
    end

    // Read then write on the same channel with start held through finish
    set_ch(0, 1'b1, 1'b0, 8'h15, 8'h00);
    @(negedge clk);
    wait_fin(0, 8, lat);
    chk("rw_rd_lat", 32'(lat + 1), 32'd3);
    set_ch(0, 1'b1, 1'b1, 8'h15, 8'hAA);
    @(negedge clk);
    chk("rw_idle_busy", 32'(busy), 32'd0);
    chk("rw_idle_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("rw_acc_we", 32'(mem_we), 32'd1);
    chk("rw_acc_adr", 32'(mem_adr), 32'h15);
    chk("rw_acc_wdata", 32'(mem_wdata), 32'hAA);
    @(negedge clk);
    chk("rw_fin", 32'(finish), 32'b001);
    chk("rw_rdata", 32'(rdata), 32'(exp_vec()));
    set_ch(0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);

    // Round robin with all channels requesting continuously
    do_reset();
    rr_val[0] = 8'hAA; rr_val[1] = 8'h5A; rr_val[2] = 8'hC3;
    set_ch(0, 1'b1, 1'b0, 8'h15, 8'h00);
    set_ch(1, 1'b1, 1'b0, 8'h20, 8'h00);
    set_ch(2, 1'b1, 1'b0, 8'hFF, 8'h00);
    for (int k = 0; k < 6; k++) begin
      found = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (finish != '0) begin
          found = 1;
          break;
        end
      end
      chk("rr_found", 32'(found), 32'd1);
      chk("rr_grant", 32'(grant), 32'(k % 3));
      chk("rr_fin", 32'(finish), 32'(1) << (k % 3));
      exp_rd[k % 3] = rr_val[k % 3];
      chk("rr_rdata", 32'(rdata), 32'(exp_vec()));
    end
    start = '0;
    @(negedge clk);

    // RD_LAT=3 instance: captured value is the one on the third WAIT cycle
    start3[0] = 1'b1; rw3[0] = 1'b0; adr3[7:0] = 8'h40;
    base = cyc3;
    @(negedge clk);
    chk("l3_adr", 32'(mem_adr3), 32'h40);
    chk("l3_busy", 32'(busy3), 32'd1);
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 3) chk("l3_hold", 32'(mem_adr3), 32'h40);
      if (finish3[0]) begin
        lat = i;
        break;
      end
    end
    chk("l3_lat", 32'(lat + 1), 32'd5);
    chk("l3_fin", 32'(finish3), 32'b001);
    chk("l3_rdata", 32'(rdata3[7:0]), 32'(8'(base + 8'd4)));
    start3 = '0;
    @(negedge clk);

    // Reset asserted while a ch1 read sits in WAIT
    set_ch(1, 1'b1, 1'b0, 8'h20, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("rw_wait_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk_reset_outputs("rstw");
    for (int i = 0; i < NCH; i++) exp_rd[i] = 8'h00;
    repeat (2) begin
      @(negedge clk);
      chk("rstw_nofin", 32'(finish), 32'd0);
    end
    reset = 1'b1;
    wait_fin(1, 8, lat);
    chk("rstw_lat", 32'(lat), 32'd3);
    chk("rstw_fin", 32'(finish), 32'b010);
    exp_rd[1] = 8'h5A;
    chk("rstw_rdata", 32'(rdata), 32'(exp_vec()));
    set_ch(1, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);

    // Ch2 withdraws before it could be granted
    do_reset();
    set_ch(0, 1'b1, 1'b0, 8'h15, 8'h00);
    @(negedge clk);
    set_ch(2, 1'b1, 1'b0, 8'h20, 8'h00);
    @(negedge clk);
    set_ch(2, 1'b0, 1'b0, 8'h20, 8'h00);
    f0 = 0; f2 = 0; g2 = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (finish[2]) f2++;
      if (busy && grant == 2'd2) g2++;
      if (finish[0]) begin
        f0++;
        set_ch(0, 1'b0, 1'b0, 8'h00, 8'h00);
      end
    end
    chk("wd_fin2", 32'(f2), 32'd0);
    chk("wd_grant2", 32'(g2), 32'd0);
    chk("wd_fin0", 32'(f0), 32'd1);
    exp_rd[0] = 8'hAA;
    chk("wd_rdata", 32'(rdata), 32'(exp_vec()));

    // Randomized requesters against a transaction-level model
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = ram[i];
    mlast = NCH - 1; next_arb = 0; arb_c = -10; done_c = -10;
    g_ch = 0; g_w = 1'b0; g_a = 8'h00; g_d = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      exp_fin = '0;
      if (c == done_c) begin
        exp_fin[g_ch] = 1'b1;
        if (g_w) ref_mem[g_a] = g_d;
        else exp_rd[g_ch] = ref_mem[g_a];
      end
      chk("rnd_fin", 32'(finish), 32'(exp_fin));
      chk("rnd_busy", 32'(busy), 32'(c > arb_c && c <= done_c));
      chk("rnd_we", 32'(mem_we), 32'(c == arb_c + 1 && g_w));
      chk("rnd_rdata", 32'(rdata), 32'(exp_vec()));
      if (c == arb_c + 1) begin
        chk("rnd_adr", 32'(mem_adr), 32'(g_a));
        chk("rnd_grant", 32'(grant), 32'(g_ch));
        if (g_w) chk("rnd_wdata", 32'(mem_wdata), 32'(g_d));
      end
      for (int ch = 0; ch < NCH; ch++) begin
        if (c == done_c && ch == g_ch) begin
          if ($urandom_range(1, 0) == 1)
            set_ch(ch, 1'b1, 1'($urandom), 8'($urandom_range(15, 0)), 8'($urandom));
          else
            start[ch] = 1'b0;
        end else if (start[ch]) begin
          if ($urandom_range(15, 0) == 0) start[ch] = 1'b0;
        end else if ($urandom_range(3, 0) == 0) begin
          set_ch(ch, 1'b1, 1'($urandom), 8'($urandom_range(15, 0)), 8'($urandom));
        end
      end
      if (c == next_arb) begin
        found = 0;
        for (int k = 1; k <= NCH; k++) begin
          cand = (mlast + k) % NCH;
          if (found == 0 && start[cand]) begin
            found = 1;
            g_ch  = cand;
          end
        end
        if (found == 1) begin
          g_w      = rw[g_ch];
          g_a      = adr[g_ch*8 +: 8];
          g_d      = wdata[g_ch*8 +: 8];
          arb_c    = c;
          done_c   = c + (g_w ? 2 : 3);
          next_arb = done_c + 1;
          mlast    = g_ch;
        end else begin
          next_arb = c + 1;
        end
      end
      @(negedge clk);
    end
    clear_inputs();
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_if_arbiter.md
Name: mem_if_arbiter

Overview:
- Parametrised successor to the single-requester decrypted-memory interface.
- Shares one synchronous single-port RAM (decrypted or s-box memory) between NUM_CH independent FSM requesters.
- Each requester keeps the same start/finish/readWrite protocol. Requests are granted round-robin, and the RAM read latency is configurable.
- Sits between the RC4 control FSMs and the on-chip RAM.

Parameters:
- NUM_CH, 3: number of requester channels (2..8).
- ADDR_W, 8: RAM address width.
- DATA_W, 8: RAM data width.
- RD_LAT, 1: RAM read latency in clocks, from the address register to valid data (1..3).

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- start, input, NUM_CH: per-channel request, level-held by the requester.
- readWrite, input, NUM_CH: per-channel operation; 0 = read, 1 = write.
- fsm_adr, input, NUM_CH*ADDR_W: per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W].
- fsm_wdata, input, NUM_CH*DATA_W: per-channel write data, packed the same way.
- finish, output, NUM_CH: per-channel one-cycle completion pulse.
- fsm_rdata, output, NUM_CH*DATA_W: per-channel read data; holds its value until that channel's next read completes.
- mem_adr, output, ADDR_W: RAM address.
- mem_we, output, 1: RAM write enable.
- mem_wdata, output, DATA_W: RAM write data.
- mem_rdata, input, DATA_W: RAM read data.
- busy, output, 1: high in every state except IDLE.
- grant_ch, output, $clog2(NUM_CH): channel currently being served; valid while busy.

Behaviour:
- Reset values (on reset low, applied asynchronously):
  - finish = 0, fsm_rdata = 0, mem_adr = 0, mem_we = 0, mem_wdata = 0, busy = 0, grant_ch = 0.
  - State = IDLE; round-robin pointer last = NUM_CH-1, so channel 0 has first priority.
- All outputs are registered.
- State machine states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - If any start bit is high, select the first set bit searching from last+1 upward, wrapping modulo NUM_CH.
  - Latch that channel's index, readWrite, address and write data.
  - Set last = granted channel and go to ACCESS.
  - If no start bit is high, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_adr and mem_wdata carry the latched values.
  - mem_we = 1 only for a write.
  - A write goes to DONE; a read goes to WAIT.
  - mem_we is 0 in every other state.
- WAIT:
  - Counts RD_LAT cycles; mem_adr is held.
  - On the last WAIT cycle, mem_rdata is captured into the granted channel's fsm_rdata slice, then the FSM goes to DONE.
- DONE (exactly 1 cycle):
  - finish[grant] = 1; all other finish bits stay 0.
  - Next state is IDLE.
- Latency from start sampled in IDLE to the finish pulse:
  - Write: 2 cycles.
  - Read: 2+RD_LAT cycles.
  - Back-to-back: one IDLE cycle follows every DONE.
- Requester rules:
  - Address, data and readWrite must be stable from start until that channel is granted.
  - After the grant, changes are ignored, because the values were latched.
  - If start is still high in the IDLE cycle after finish, it is a new request. Changing readWrite/address/data at the finish edge is therefore legal.
- Simultaneous requests: exactly one grant per transaction. No channel waits more than NUM_CH-1 transactions.
- Start deasserted by a requester before its grant: that request is dropped, with no finish. Deassertion after the grant: the transaction completes normally.
- Reset mid-transaction: the FSM returns to IDLE immediately. No finish is generated, mem_we drops to 0, and pending requests are re-arbitrated from channel 0 after reset release.
- fsm_rdata slices for other channels and for write transactions are never modified.

Test Plan:
- Single read, RD_LAT=1:
  - Stimulus: start[0]=1, readWrite[0]=0, fsm_adr ch0 = 0x15, mem_rdata = 0xBB.
  - Required: mem_adr = 0x15 in ACCESS; finish[0] pulses 3 cycles after start is sampled; fsm_rdata ch0 = 0xBB.
- Read then write on the same channel:
  - Stimulus: hold start[0]; on finish switch to readWrite = 1, data 0xAA.
  - Required: after exactly one IDLE cycle, ACCESS shows mem_adr = 0x15, mem_we = 1, mem_wdata = 0xAA; finish[0] pulses 2 cycles later; fsm_rdata ch0 stays 0xBB.
- Round-robin:
  - Stimulus: start = 3'b111 held continuously, all channels reading.
  - Required: grant order 0,1,2,0,1,2; exactly one finish bit per DONE; no channel starves.
- RD_LAT=3 build:
  - Stimulus: a read of address 0x40 with mem_rdata changing each cycle.
  - Required: finish arrives at 5 cycles; the captured value is the one present on the third WAIT cycle.
- Reset in WAIT:
  - Stimulus: assert reset low while a ch1 read is in WAIT.
  - Required: all outputs reset immediately; no finish[1]; after release with start[1] still high, ch1 completes normally.
- Early withdrawal:
  - Stimulus: ch2 raises start while ch0 is busy, then drops it before its grant.
  - Required: ch2 is never granted and finish[2] stays 0.
